// File: rtl/counter_pkg.sv
// Shared counter definitions: direction/mode encodings and the next-value function
// used by every counter variant. Values are carried in a 64-bit container.
package counter_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;

    localparam int   MODE_WRAP = 0;
    localparam int   MODE_SAT  = 1;

    // Counters may be at most CNT_W-1 bits, so the arithmetic always has a spare top bit.
    localparam int   CNT_W     = 64;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        cnt_t val;
        logic bnd;
    } next_t;

    function automatic next_t next_count(input cnt_t cur, input logic up, input cnt_t max,
                                         input logic sat);
        next_t r;
        r.bnd = 1'b0;
        r.val = cur;
        if (up == DIR_DOWN) begin
            if (cur == '0) begin
                r.bnd = 1'b1;
                r.val = sat ? '0 : max;
            end else begin
                r.val = cur - cnt_t'(1);
            end
        end else begin
            if (cur >= max) begin
                r.bnd = 1'b1;
                r.val = sat ? max : '0;
            end else begin
                r.val = cur + cnt_t'(1);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with load, wrap/saturate, terminal-count pulse and sticky ovf/udf.
// One cycle latency from any input to every (registered) output.
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int              WIDTH     = 4,
    parameter longint unsigned MAX_COUNT = (64'd1 << WIDTH) - 64'd1,
    parameter int              SATURATE  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf,
    output logic             udf
);

    if (WIDTH < 1 || WIDTH > CNT_W - 1 || MAX_COUNT < 64'd1 ||
        MAX_COUNT > (64'd1 << WIDTH) - 64'd1 ||
        (SATURATE != MODE_WRAP && SATURATE != MODE_SAT)) begin : g_param_check
        $fatal(1, "updown_mod_counter: illegal WIDTH/MAX_COUNT/SATURATE");
    end

    localparam cnt_t             MAX_C  = cnt_t'(MAX_COUNT);
    localparam logic [WIDTH-1:0] MAX_W  = MAX_C[WIDTH-1:0];
    localparam logic             SAT_EN = (SATURATE != MODE_WRAP);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             set_ovf, set_udf;
    next_t            nc;
    cnt_t             unused_hi;

    assign unused_hi = nc.val >> WIDTH;

    always_comb begin
        nc      = next_count(cnt_t'(count_q), up_dn == DIR_UP, MAX_C, SAT_EN);
        count_d = count_q;
        tc_d    = 1'b0;
        set_ovf = 1'b0;
        set_udf = 1'b0;
        if (load) begin
            count_d = (cnt_t'(load_val) > MAX_C) ? MAX_W : load_val;
        end else if (en) begin
            count_d = nc.val[WIDTH-1:0];
            tc_d    = nc.bnd;
            set_ovf = nc.bnd & (up_dn == DIR_UP);
            set_udf = nc.bnd & (up_dn != DIR_UP);
        end
        // A boundary event in the same cycle as a clear leaves the flag set.
        ovf_d = (ovf_q & ~clr_flags) | set_ovf;
        udf_d = (udf_q & ~clr_flags) | set_udf;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign ovf   = ovf_q;
    assign udf   = udf_q;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed bench for a wrapping and a saturating counter (both WIDTH=4, MAX_COUNT=9)
// with an independent reference model feeding an expected-value queue.
module tb_updown_mod_counter;

    localparam int MAXC = 9;

    typedef struct packed {
        logic       sel;
        logic [3:0] cnt;
        logic       tc;
        logic       ovf;
        logic       udf;
    } exp_t;

    logic       clk = 1'b0;
    logic       a_reset, a_en, a_up, a_load, a_clr;
    logic [3:0] a_lv;
    logic [3:0] a_count;
    logic       a_tc, a_ovf, a_udf;
    logic       b_reset, b_en, b_up, b_load, b_clr;
    logic [3:0] b_lv;
    logic [3:0] b_count;
    logic       b_tc, b_ovf, b_udf;

    exp_t       sbq[$];
    int         m_cnt[2];
    logic       m_tc[2];
    logic       m_ovf[2];
    logic       m_udf[2];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    updown_mod_counter #(.WIDTH(4), .MAX_COUNT(64'd9), .SATURATE(0)) u_wrap (
        .clk(clk), .reset(a_reset), .en(a_en), .up_dn(a_up), .load(a_load),
        .load_val(a_lv), .clr_flags(a_clr), .count(a_count), .tc(a_tc),
        .ovf(a_ovf), .udf(a_udf)
    );

    updown_mod_counter #(.WIDTH(4), .MAX_COUNT(64'd9), .SATURATE(1)) u_sat (
        .clk(clk), .reset(b_reset), .en(b_en), .up_dn(b_up), .load(b_load),
        .load_val(b_lv), .clr_flags(b_clr), .count(b_count), .tc(b_tc),
        .ovf(b_ovf), .udf(b_udf)
    );

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle on the selected instance, predict, then compare after the edge.
    task automatic step(input int sel, input bit rst, input bit en, input bit up,
                        input bit ld, input logic [3:0] lv, input bit clr);
        bit   sat;
        bit   so, su;
        exp_t e;
        exp_t got;
        sat = (sel == 1);
        so  = 1'b0;
        su  = 1'b0;
        {a_reset, a_en, a_up, a_load, a_clr, a_lv} = '0;
        {b_reset, b_en, b_up, b_load, b_clr, b_lv} = '0;
        if (sel == 0) {a_reset, a_en, a_up, a_load, a_clr, a_lv} = {rst, en, up, ld, clr, lv};
        else          {b_reset, b_en, b_up, b_load, b_clr, b_lv} = {rst, en, up, ld, clr, lv};

        if (rst) begin
            m_cnt[sel] = 0; m_tc[sel] = 1'b0; m_ovf[sel] = 1'b0; m_udf[sel] = 1'b0;
        end else begin
            m_tc[sel] = 1'b0;
            if (ld) begin
                m_cnt[sel] = (int'(lv) > MAXC) ? MAXC : int'(lv);
            end else if (en && up) begin
                if (m_cnt[sel] == MAXC) begin
                    m_cnt[sel] = sat ? MAXC : 0; m_tc[sel] = 1'b1; so = 1'b1;
                end else m_cnt[sel] = m_cnt[sel] + 1;
            end else if (en) begin
                if (m_cnt[sel] == 0) begin
                    m_cnt[sel] = sat ? 0 : MAXC; m_tc[sel] = 1'b1; su = 1'b1;
                end else m_cnt[sel] = m_cnt[sel] - 1;
            end
            m_ovf[sel] = (m_ovf[sel] && !clr) || so;
            m_udf[sel] = (m_udf[sel] && !clr) || su;
        end
        e.sel = sel[0];
        e.cnt = m_cnt[sel][3:0];
        e.tc  = m_tc[sel];
        e.ovf = m_ovf[sel];
        e.udf = m_udf[sel];
        sbq.push_back(e);

        @(posedge clk);
        #1;
        e = sbq.pop_front();
        if (e.sel == 1'b0) got = '{1'b0, a_count, a_tc, a_ovf, a_udf};
        else               got = '{1'b1, b_count, b_tc, b_ovf, b_udf};
        check(e.sel ? "sat.count" : "wrap.count", got.cnt, e.cnt);
        check(e.sel ? "sat.tc"    : "wrap.tc",    {3'b0, got.tc},  {3'b0, e.tc});
        check(e.sel ? "sat.ovf"   : "wrap.ovf",   {3'b0, got.ovf}, {3'b0, e.ovf});
        check(e.sel ? "sat.udf"   : "wrap.udf",   {3'b0, got.udf}, {3'b0, e.udf});
    endtask

    initial begin
        {a_reset, a_en, a_up, a_load, a_clr, a_lv} = '0;
        {b_reset, b_en, b_up, b_load, b_clr, b_lv} = '0;
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_tc[i] = 1'b0; m_ovf[i] = 1'b0; m_udf[i] = 1'b0;
        end

        // Wrapping instance: count up through the terminal value.
        step(0, 1, 0, 0, 0, 4'd0, 0);
        step(0, 1, 0, 0, 0, 4'd0, 0);
        for (int i = 0; i < 12; i++) step(0, 0, 1, 1, 0, 4'd0, 0);

        // Count down from zero after reset.
        step(0, 1, 0, 0, 0, 4'd0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 4'd0, 0);

        // Load clamping and load priority over enable.
        step(0, 0, 0, 0, 1, 4'd12, 0);
        step(0, 0, 1, 1, 1, 4'd5, 0);
        step(0, 0, 0, 0, 1, 4'd15, 0);

        // Hold with en=0, then direction change mid-count.
        step(0, 0, 0, 1, 0, 4'd0, 0);
        step(0, 0, 0, 0, 1, 4'd4, 0);
        step(0, 0, 1, 1, 0, 4'd0, 0);
        step(0, 0, 1, 0, 0, 4'd0, 0);
        step(0, 0, 1, 0, 0, 4'd0, 0);

        // Saturating instance: hold at the top, then at the bottom.
        step(1, 1, 0, 0, 0, 4'd0, 0);
        step(1, 0, 0, 0, 1, 4'd8, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 1, 1, 0, 4'd0, 0);
        step(1, 0, 0, 0, 1, 4'd0, 0);
        step(1, 0, 1, 0, 0, 4'd0, 0);
        step(1, 0, 1, 0, 0, 4'd0, 0);
        step(1, 0, 0, 0, 0, 4'd0, 1);

        // Reset wins over load, enable and clear mid-count.
        step(0, 0, 0, 0, 1, 4'd3, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0, 4'd0, 0);
        step(0, 1, 1, 1, 1, 4'd7, 1);

        // Set beats clear on the same edge; a lone clear then drops the flag.
        step(0, 0, 0, 0, 1, 4'd9, 0);
        step(0, 0, 1, 1, 0, 4'd0, 0);
        step(0, 0, 0, 0, 1, 4'd9, 0);
        step(0, 0, 1, 1, 0, 4'd0, 1);
        step(0, 0, 0, 0, 0, 4'd0, 1);

        // Same for underflow.
        step(0, 0, 1, 0, 0, 4'd0, 0);
        step(0, 0, 0, 0, 1, 4'd0, 0);
        step(0, 0, 1, 0, 0, 4'd0, 1);
        step(0, 0, 0, 0, 0, 4'd0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/updown_mod_counter.md
Name: updown_mod_counter

Overview:
Parametrised modulo counter, the next generation of the team's fixed 4-bit up counter.
- Adds generic width, programmable terminal value, up/down direction, count enable, synchronous parallel load and a wrap or saturate mode.
- Flags boundary events with a one-cycle terminal-count pulse and sticky overflow/underflow flags.
- Used as a general timebase/event counter in datapath and control blocks.

Parameters:
WIDTH, 4, counter width in bits (>= 1)
MAX_COUNT, 2**WIDTH-1, terminal value; count range is 0..MAX_COUNT; must satisfy 1 <= MAX_COUNT <= 2**WIDTH-1
SATURATE, 0, 0 = wrap at bounds, 1 = hold at bounds

Ports:
clk  input  1  single system clock, rising edge
reset  input  1  synchronous, active-high reset
en  input  1  count enable
up_dn  input  1  direction: 1 = up, 0 = down; sampled only when en=1
load  input  1  synchronous parallel load strobe
load_val  input  WIDTH  value loaded when load=1
clr_flags  input  1  clears ovf/udf
count  output  WIDTH  registered count value
tc  output  1  registered terminal-count pulse
ovf  output  1  sticky: an up-count hit MAX_COUNT boundary
udf  output  1  sticky: a down-count hit 0 boundary

Behaviour:
- All state updates on rising clk. Reset is synchronous and active-high. No combinational input-to-output paths; all outputs are registered.
- Reset: count=0, tc=0, ovf=0, udf=0. Reset has highest priority and overrides load, en and clr_flags in the same cycle. Reset mid-count returns to 0 on the next edge.
- Priority below reset: load > en > hold.
- load=1:
  - count <= load_val if load_val <= MAX_COUNT, else count <= MAX_COUNT (clamp).
  - tc=0 that cycle; ovf/udf unaffected by load.
- en=1, up_dn=1:
  - If count < MAX_COUNT: count+1.
  - If count == MAX_COUNT: next = 0 (SATURATE=0) or MAX_COUNT (SATURATE=1); tc=1; ovf set.
- en=1, up_dn=0:
  - If count > 0: count-1.
  - If count == 0: next = MAX_COUNT (SATURATE=0) or 0 (SATURATE=1); udf set; tc=1.
- en=0 and load=0: count holds; tc=0.
- tc timing:
  - Asserted for exactly the cycle following the edge on which the boundary event is taken, i.e. coincident with the wrapped/held count value.
  - In SATURATE=1 mode, tc re-asserts on every enabled cycle that attempts to move past a bound.
- Latency: one clock from input to count/tc/flags.
- clr_flags=1 clears ovf and udf on the next edge. If a new boundary event occurs in the same cycle, set wins and the flag reads 1.
- Direction change mid-count is legal and takes effect on the same edge, with no extra latency.
- Arithmetic: internal next-value logic is WIDTH+1 bits wide so that MAX_COUNT = 2**WIDTH-1 wraps without relying on natural overflow. count never exceeds MAX_COUNT.
- Elaboration-time check: MAX_COUNT out of range or WIDTH < 1 is a fatal error.

Decomposition:
- Shared package counter_pkg:
  - Direction constants DIR_UP=1'b1, DIR_DOWN=1'b0.
  - Mode constants MODE_WRAP=0, MODE_SAT=1.
  - Pure function next_count(cur, up, max, sat) returning next value plus boundary flag, shared with other counter variants and the bench reference model.
- No sub-module: a single always block for state plus the package function is natural at this size.

Test Plan:
1. WIDTH=4, MAX_COUNT=9, SATURATE=0; reset 2 cycles, then en=1, up_dn=1 for 12 cycles -> count 0,1,..,9,0,1; tc=1 only in the cycle count shows 0 after 9; ovf=1 thereafter; udf=0.
2. Same instance, reset then en=1, up_dn=0 -> count 9,8,...; tc=1 with first 9; udf=1; ovf=0.
3. load=1, load_val=12 -> count=9 (clamped). Then load=1, load_val=5 with en=1, up_dn=1 -> count=5 (load beats en), tc=0.
4. SATURATE=1 instance, MAX_COUNT=9; load 8, en=1 up for 4 cycles -> count 9,9,9,9; tc=0,1,1,1. Then down from loaded 0 -> count stays 0, tc=1, udf=1.
5. Counting up at count=6 with load=1 and clr_flags=1 also asserted, assert reset -> next count=0, tc=0, ovf=0, udf=0.
6. ovf=1, count=9, en=1 up with clr_flags=1 same cycle -> count=0, tc=1, ovf stays 1. Next cycle clr_flags=1 alone -> ovf=0.
